keypad_scan_ctrl: RTL and testbench
===================================

KEYPAD_SCAN_CTRL -- requirements
Module: keypad_scan_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000: clock cycles each column is driven during scanning; legal values are 4 or more.
REQ-002 SHALL have parameter DEBOUNCE_CNT, default 20000: number of consecutive stable synchronized samples required for press or release; legal values are 2 or more.
REQ-003 SHALL have parameter INT_WIDTH, default 6: number of cycles the interrupt is held high per accepted key; legal values are 1 or more.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port row, input, 4 bits: keypad row lines, active-high, asynchronous to clk.
REQ-007 SHALL have port col, output, 3 bits: one-hot column drive.
REQ-008 SHALL have port key_code, output, 4 bits: code of the last accepted key.
REQ-009 SHALL have port interrupt, output, 1 bit: goes to the CPU interrupt input; high for INT_WIDTH cycles per accepted key.

Function
REQ-010 SHALL pass row through a 2-flop synchronizer (row_s); all decisions SHALL use row_s only.
REQ-011 SHALL implement the states SCAN, DEBOUNCE, REPORT and RELEASE.
REQ-012 SCAN: col SHALL rotate 001 -> 010 -> 100 -> 001, each column held SCAN_DIV cycles, using a scan counter running 0..SCAN_DIV-1 that resets on every column change.
REQ-013 SCAN: while the scan counter is 0 or 1, row_s SHALL be ignored, allowing for settling plus synchronizer latency.
REQ-014 SCAN, scan counter 2 or more, row_s with exactly one bit set: SHALL go to DEBOUNCE on the next edge.
- On that edge: capture pattern P = row_s and the current col.
- Freeze col.
- Set the debounce counter to 1.
REQ-015 SCAN, row_s with zero bits or two or more bits set: SHALL keep scanning; multi-row presses are never accepted.
REQ-016 DEBOUNCE: each cycle with row_s == P SHALL increment the debounce counter.
REQ-017 DEBOUNCE: when the counter reaches DEBOUNCE_CNT, SHALL go to REPORT on that edge.
REQ-018 DEBOUNCE: any cycle with row_s != P SHALL return to SCAN.
- Same column.
- Scan counter reset to 0.
- No key_code change and no interrupt.
REQ-019 On the DEBOUNCE -> REPORT edge, key_code SHALL update according to row/col as follows:
- Row 0: col0 = 1, col1 = 2, col2 = 3.
- Row 1: col0 = 4, col1 = 5, col2 = 6.
- Row 2: col0 = 7, col1 = 8, col2 = 9.
- Row 3: col0 = 0xA (*), col1 = 0x0, col2 = 0xB (#).
REQ-020 interrupt SHALL be high exactly while in REPORT.
- REPORT lasts INT_WIDTH cycles.
- interrupt rises on the same edge that key_code updates.
REQ-021 REPORT: after INT_WIDTH cycles SHALL go to RELEASE regardless of row_s; col stays frozen.
REQ-022 RELEASE: SHALL count consecutive cycles with row_s == 0.
- Any nonzero row_s resets the count to 0.
- When the count reaches DEBOUNCE_CNT, SHALL go to SCAN with the same column and scan counter 0.
REQ-023 A key held for any duration SHALL produce exactly one interrupt pulse; a new pulse requires a debounced release first.
REQ-024 key_code SHALL hold its value through SCAN, DEBOUNCE and RELEASE until the next accepted key.
REQ-025 No state SHALL be unreachable; illegal state encodings SHALL return to SCAN on the next edge with interrupt = 0.

Reset
REQ-026 While rst_n = 0, the following SHALL hold immediately, independent of clk:
- State = SCAN.
- col = 001.
- Scan, debounce and release counters = 0.
- Synchronizer flops = 0.
- key_code = 0xF (no key).
- interrupt = 0.
REQ-027 Assertion of rst_n in any state, including mid-REPORT, SHALL force interrupt low immediately with no further pulse after release.
REQ-028 Scanning SHALL start at col = 001 on the first clk edge after rst_n deasserts.

Verification (SCAN_DIV=4, DEBOUNCE_CNT=3, INT_WIDTH=6)
REQ-029 Reset, no press -> col cycles 001, 010, 100, 001, each for 4 cycles; interrupt = 0; key_code = 0xF.
REQ-030 Hold row = 0010 whenever col = 010, held 50 cycles -> key_code = 5; interrupt high for exactly 6 cycles; exactly one pulse in total.
REQ-031 Row = 0010 for 2 cycles only (bounce), then 0 -> no interrupt; key_code unchanged; scanning resumes.
REQ-032 Row = 1000 on col = 100, released for 3 or more cycles, then pressed again -> two separate 6-cycle pulses; key_code = 0xB both times.
REQ-033 Row = 0011 (two rows) held -> no interrupt; col keeps rotating.
REQ-034 rst_n = 0 on the 3rd cycle of interrupt -> interrupt = 0 and key_code = 0xF that same cycle; on release, col = 001 and there is no interrupt while the key stays held until it passes debounce again.

Source files
------------

// File: rtl/keypad_scan_ctrl.sv
// 4x3 matrix keypad scanner: rotates one-hot column drive, debounces a single
// pressed key, latches its code and raises a fixed-width interrupt pulse.
module keypad_scan_ctrl #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 20000,
  parameter int INT_WIDTH    = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row,
  output logic [2:0] col,
  output logic [3:0] key_code,
  output logic       interrupt
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DEBOUNCE_CNT + 1);
  localparam int IW = (INT_WIDTH > 1) ? $clog2(INT_WIDTH) : 1;
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DEB_TARGET = DW'(DEBOUNCE_CNT);
  localparam logic [IW-1:0] INT_LAST   = IW'(INT_WIDTH - 1);

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_REPORT   = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  state_t        state_r, state_nxt_s;
  logic [3:0]    row_meta_r, row_sync_r;
  logic [2:0]    col_r, col_nxt_s;
  logic [SW-1:0] scan_cnt_r, scan_cnt_nxt_s;
  logic [DW-1:0] deb_cnt_r, deb_cnt_nxt_s;
  logic [DW-1:0] rel_cnt_r, rel_cnt_nxt_s;
  logic [IW-1:0] rep_cnt_r, rep_cnt_nxt_s;
  logic [3:0]    pat_r, pat_nxt_s;
  logic [3:0]    key_code_r, key_code_nxt_s;
  logic          interrupt_r, interrupt_nxt_s;

  function automatic logic is_onehot(input logic [3:0] v);
    is_onehot = (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  // Row 3 carries '*', '0', '#'; anything unexpected maps to "no key".
  function automatic logic [3:0] key_lookup(input logic [3:0] r, input logic [2:0] c);
    case ({r, c})
      7'b0001_001: key_lookup = 4'h1;
      7'b0001_010: key_lookup = 4'h2;
      7'b0001_100: key_lookup = 4'h3;
      7'b0010_001: key_lookup = 4'h4;
      7'b0010_010: key_lookup = 4'h5;
      7'b0010_100: key_lookup = 4'h6;
      7'b0100_001: key_lookup = 4'h7;
      7'b0100_010: key_lookup = 4'h8;
      7'b0100_100: key_lookup = 4'h9;
      7'b1000_001: key_lookup = 4'hA;
      7'b1000_010: key_lookup = 4'h0;
      7'b1000_100: key_lookup = 4'hB;
      default:     key_lookup = 4'hF;
    endcase
  endfunction

  // Two-flop synchronizer for the asynchronous row lines.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta_r <= 4'd0;
      row_sync_r <= 4'd0;
    end else begin
      row_meta_r <= row;
      row_sync_r <= row_meta_r;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_SCAN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state plus next values of every counter and output register.
  always_comb begin
    state_nxt_s    = state_r;
    col_nxt_s      = col_r;
    scan_cnt_nxt_s = scan_cnt_r;
    deb_cnt_nxt_s  = deb_cnt_r;
    rel_cnt_nxt_s  = rel_cnt_r;
    rep_cnt_nxt_s  = rep_cnt_r;
    pat_nxt_s      = pat_r;
    key_code_nxt_s = key_code_r;
    case (state_r)
      ST_SCAN: begin
        // The first two counts of each column cover line settling and synchronizer delay.
        if ((scan_cnt_r >= SW'(2)) && is_onehot(row_sync_r)) begin
          state_nxt_s   = ST_DEBOUNCE;
          pat_nxt_s     = row_sync_r;
          deb_cnt_nxt_s = DW'(1);
        end else if (scan_cnt_r == SCAN_LAST) begin
          col_nxt_s      = {col_r[1:0], col_r[2]};
          scan_cnt_nxt_s = {SW{1'b0}};
        end else begin
          scan_cnt_nxt_s = scan_cnt_r + SW'(1);
        end
      end
      ST_DEBOUNCE: begin
        if (row_sync_r == pat_r) begin
          deb_cnt_nxt_s = deb_cnt_r + DW'(1);
          if ((deb_cnt_r + DW'(1)) == DEB_TARGET) begin
            state_nxt_s    = ST_REPORT;
            key_code_nxt_s = key_lookup(pat_r, col_r);
            rep_cnt_nxt_s  = {IW{1'b0}};
          end else begin
            state_nxt_s = ST_DEBOUNCE;
          end
        end else begin
          state_nxt_s    = ST_SCAN;
          scan_cnt_nxt_s = {SW{1'b0}};
          deb_cnt_nxt_s  = {DW{1'b0}};
        end
      end
      ST_REPORT: begin
        if (rep_cnt_r == INT_LAST) begin
          state_nxt_s   = ST_RELEASE;
          rel_cnt_nxt_s = {DW{1'b0}};
        end else begin
          rep_cnt_nxt_s = rep_cnt_r + IW'(1);
        end
      end
      ST_RELEASE: begin
        if (row_sync_r == 4'd0) begin
          if ((rel_cnt_r + DW'(1)) == DEB_TARGET) begin
            state_nxt_s    = ST_SCAN;
            scan_cnt_nxt_s = {SW{1'b0}};
            rel_cnt_nxt_s  = {DW{1'b0}};
          end else begin
            rel_cnt_nxt_s = rel_cnt_r + DW'(1);
          end
        end else begin
          rel_cnt_nxt_s = {DW{1'b0}};
        end
      end
      default: begin
        state_nxt_s    = ST_SCAN;
        scan_cnt_nxt_s = {SW{1'b0}};
      end
    endcase
    interrupt_nxt_s = (state_nxt_s == ST_REPORT);
  end

  // Datapath registers; interrupt is registered so it tracks REPORT exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_r       <= 3'b001;
      scan_cnt_r  <= {SW{1'b0}};
      deb_cnt_r   <= {DW{1'b0}};
      rel_cnt_r   <= {DW{1'b0}};
      rep_cnt_r   <= {IW{1'b0}};
      pat_r       <= 4'd0;
      key_code_r  <= 4'hF;
      interrupt_r <= 1'b0;
    end else begin
      col_r       <= col_nxt_s;
      scan_cnt_r  <= scan_cnt_nxt_s;
      deb_cnt_r   <= deb_cnt_nxt_s;
      rel_cnt_r   <= rel_cnt_nxt_s;
      rep_cnt_r   <= rep_cnt_nxt_s;
      pat_r       <= pat_nxt_s;
      key_code_r  <= key_code_nxt_s;
      interrupt_r <= interrupt_nxt_s;
    end
  end

  assign col       = col_r;
  assign key_code  = key_code_r;
  assign interrupt = interrupt_r;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: a behavioural keypad drives row from col, a pulse
// monitor tracks interrupts, and directed plus random presses are checked.
module tb_keypad_scan_ctrl;
  localparam int SCAN_DIV     = 4;
  localparam int DEBOUNCE_CNT = 3;
  localparam int INT_WIDTH    = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] row = 4'd0;
  logic [2:0] col;
  logic [3:0] key_code;
  logic       interrupt;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   pulses = 0;
  int   rise_cyc = 0;
  int   run_len = 0;
  logic int_prev = 1'b0;

  // Keypad model: one pressed key at (prow, pcol), or a forced raw row pattern.
  logic       pressed = 1'b0;
  int         prow = 0;
  int         pcol = 0;
  logic       forced = 1'b0;
  logic [3:0] forced_row = 4'd0;

  always #5 clk = ~clk;

  keypad_scan_ctrl #(
    .SCAN_DIV(SCAN_DIV),
    .DEBOUNCE_CNT(DEBOUNCE_CNT),
    .INT_WIDTH(INT_WIDTH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .row(row),
    .col(col),
    .key_code(key_code),
    .interrupt(interrupt)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] keypad_rows(input logic [2:0] c);
    if (forced) return forced_row;
    if (pressed && c[pcol]) return 4'(1 << prow);
    return 4'd0;
  endfunction

  function automatic int exp_key(input int r, input int c);
    if (r < 3) return r * 3 + c + 1;
    if (c == 0) return 10;
    if (c == 1) return 0;
    return 11;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    chk("col_onehot", $countones(col), 1);
    if (interrupt && !int_prev) begin
      pulses++;
      rise_cyc = cyc;
      run_len  = 1;
    end else if (interrupt) begin
      run_len++;
    end else if (int_prev) begin
      chk("pulse_width", run_len, INT_WIDTH);
    end
    int_prev = interrupt;
    row = keypad_rows(col);
  endtask

  task automatic do_reset(input int hold);
    rst_n = 1'b0;
    int_prev = 1'b0;
    run_len = 0;
    #1;
    chk("rst_interrupt", int'(interrupt), 0);
    chk("rst_key", int'(key_code), 15);
    chk("rst_col", int'(col), 1);
    row = keypad_rows(col);
    repeat (hold) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    row = keypad_rows(col);
  endtask

  initial begin
    int p0;
    int changes;
    logic [2:0] prev_col;
    int r;
    int c;
    int extra;

    #2;
    do_reset(2);

    // Idle scan: column index advances every SCAN_DIV cycles from deassertion.
    for (int k = 1; k <= 24; k++) begin
      tick();
      chk("scan_col", int'(col), 1 << ((cyc / SCAN_DIV) % 3));
      chk("scan_int", int'(interrupt), 0);
    end
    chk("scan_key", int'(key_code), 15);

    // Key '5' held from reset: column 1 reached at cycle 4, +2 sync, +3 debounce.
    pressed = 1'b1; prow = 1; pcol = 1;
    p0 = pulses;
    do_reset(2);
    repeat (50) tick();
    chk("k5_rise_cycle", rise_cyc, 9);
    chk("k5_pulses", pulses - p0, 1);
    chk("k5_key", int'(key_code), 5);
    pressed = 1'b0;
    repeat (20) tick();
    chk("k5_pulses_after", pulses - p0, 1);
    chk("k5_key_hold", int'(key_code), 5);

    // Two-sample bounce aligned to a fresh column: must not be accepted.
    p0 = pulses;
    prev_col = col;
    for (int i = 0; i < 8 && col == prev_col; i++) tick();
    forced = 1'b1; forced_row = 4'b0010; row = forced_row;
    tick();
    tick();
    forced_row = 4'd0; row = 4'd0;
    forced = 1'b0;
    repeat (4) tick();
    changes = 0;
    prev_col = col;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (col != prev_col) changes++;
      prev_col = col;
    end
    chk("bounce_pulses", pulses - p0, 0);
    chk("bounce_key", int'(key_code), 5);
    chk("bounce_rescan", int'(changes >= 3), 1);

    // '#' pressed, released, pressed again: two separate pulses.
    pressed = 1'b1; prow = 3; pcol = 2;
    p0 = pulses;
    for (int i = 0; i < 40 && pulses == p0; i++) tick();
    repeat (20) tick();
    chk("hash1_pulses", pulses - p0, 1);
    chk("hash1_key", int'(key_code), 11);
    pressed = 1'b0;
    repeat (8) tick();
    pressed = 1'b1;
    for (int i = 0; i < 40 && pulses == p0 + 1; i++) tick();
    repeat (20) tick();
    chk("hash2_pulses", pulses - p0, 2);
    chk("hash2_key", int'(key_code), 11);
    pressed = 1'b0;
    repeat (10) tick();

    // Two rows at once: never accepted, scanning continues.
    forced = 1'b1; forced_row = 4'b0011; row = forced_row;
    p0 = pulses;
    changes = 0;
    prev_col = col;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (col != prev_col) changes++;
      prev_col = col;
    end
    chk("multi_pulses", pulses - p0, 0);
    chk("multi_rotate", int'(changes >= 7), 1);
    forced = 1'b0; row = 4'd0;
    repeat (4) tick();

    // Reset during the third interrupt cycle while the key stays held.
    pressed = 1'b1; prow = 1; pcol = 1;
    p0 = pulses;
    for (int i = 0; i < 40 && pulses == p0; i++) tick();
    tick();
    tick();
    chk("midrpt_int_high", int'(interrupt), 1);
    #2;
    do_reset(2);
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("postrst_no_int", int'(interrupt), 0);
      if (k <= 3) chk("postrst_col", int'(col), 1);
    end
    tick();
    chk("postrst_redetect", int'(interrupt), 1);
    chk("postrst_key", int'(key_code), 5);
    repeat (20) tick();
    pressed = 1'b0;
    repeat (12) tick();

    // Random single-key presses with random hold lengths.
    for (int it = 0; it < 10; it++) begin
      r = int'($urandom_range(0, 3));
      c = int'($urandom_range(0, 2));
      pressed = 1'b1; prow = r; pcol = c;
      p0 = pulses;
      for (int i = 0; i < 60 && pulses == p0; i++) tick();
      chk("rnd_accept", pulses - p0, 1);
      chk("rnd_key", int'(key_code), exp_key(r, c));
      extra = 6 + int'($urandom_range(0, 25));
      repeat (extra) tick();
      pressed = 1'b0;
      repeat (12) tick();
      chk("rnd_single_pulse", pulses - p0, 1);
      chk("rnd_key_hold", int'(key_code), exp_key(r, c));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
